// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the program loader.
// The loader takes the slave side; the byte source and RAM take the master side.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output byte_data, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_data, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: assembles little-endian words from a byte stream, writes them
// sequentially from address 0, and holds the core in reset until the program is complete.
module imem_loader #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_start,
  input  logic [ADDR_W:0] load_len,
  imem_loader_if.slave    bus,
  output logic            load_busy,
  output logic            load_done,
  output logic            load_err,
  output logic            core_rst_n
);

  localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W:0] MaxLen  = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRecv  = 3'd1;
  localparam logic [2:0] StWrite = 3'd2;
  localparam logic [2:0] StDone  = 3'd3;
  localparam logic [2:0] StErr   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [31:0]     word_q, word_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            accept;

  assign accept = (state_q == StRecv) && bus.byte_valid;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    word_d  = word_q;
    tmo_d   = tmo_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (load_start) begin
          if (load_len == '0) begin
            state_d = StDone;
          end else if (load_len > MaxLen) begin
            state_d = StErr;
          end else begin
            len_d   = load_len;
            cnt_d   = '0;
            idx_d   = '0;
            tmo_d   = '0;
            state_d = StRecv;
          end
        end
      end
      StRecv: begin
        if (accept) begin
          word_d[{idx_q, 3'b000} +: 8] = bus.byte_data;
          idx_d = idx_q + 2'd1;
          tmo_d = '0;
          if (idx_q == 2'd3) state_d = StWrite;
        end else if (tmo_q == TmoLast) begin
          // Stalled stream: drop the partial word rather than write garbage.
          state_d = StErr;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StWrite: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_d == len_q) ? StDone : StRecv;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      tmo_q   <= tmo_d;
    end
  end

  // Every output is a state decode or a register; nothing flows straight from an input.
  assign bus.byte_ready = (state_q == StRecv);
  assign bus.wr_en      = (state_q == StWrite);
  assign bus.wr_addr    = cnt_q[ADDR_W-1:0];
  assign bus.wr_data    = word_q;
  assign load_busy      = (state_q == StRecv) || (state_q == StWrite);
  assign load_done      = (state_q == StDone);
  assign load_err       = (state_q == StErr);
  assign core_rst_n     = (state_q == StDone);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal loads, stalls, timeout, length limits,
// mid-load reset and a full-depth load, checked against hand-computed words.
module tb_imem_loader;

  localparam int unsigned ADDR_W         = 12;
  localparam int unsigned TIMEOUT_CYCLES = 1024;

  logic            clk        = 1'b0;
  logic            rst_n      = 1'b1;
  logic            load_start = 1'b0;
  logic [ADDR_W:0] load_len   = '0;
  logic            load_busy;
  logic            load_done;
  logic            load_err;
  logic            core_rst_n;

  int compared   = 0;
  int mismatched = 0;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_len   (load_len),
    .bus        (bus),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .core_rst_n (core_rst_n)
  );

  always #5 clk = ~clk;

  // Write log, captured mid-cycle: {addr, data} for every cycle wr_en is high.
  logic [ADDR_W+31:0] wlog[$];
  always @(negedge clk) if (bus.wr_en === 1'b1) wlog.push_back({bus.wr_addr, bus.wr_data});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [ADDR_W:0] len);
    load_len   = len;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Present a byte and hold it until an edge with byte_ready high takes it.
  task automatic push(input logic [7:0] b);
    logic ok;
    ok             = 1'b0;
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 8 && !ok; i++) begin
      ok = bus.byte_ready;
      tick();
    end
    chk("push_accept", {63'd0, ok}, 64'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] wa;
    int          bad;
    bus.byte_data  = 8'h00;
    bus.byte_valid = 1'b1;

    // Reset with byte_valid asserted
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", bus.byte_ready, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_status", {load_busy, load_done, load_err, core_rst_n}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_ready", bus.byte_ready, 0);
    bus.byte_valid = 1'b0;

    // Two-word load, continuous stream
    start(2);
    wlog.delete();
    chk("t2_busy", {load_busy, bus.byte_ready, core_rst_n}, 3'b110);
    push(8'h78); push(8'h56); push(8'h34); push(8'h12);
    chk("t2_w0_en", bus.wr_en, 1);
    chk("t2_w0_addr", bus.wr_addr, 0);
    chk("t2_w0_data", bus.wr_data, 32'h12345678);
    chk("t2_w0_ready", bus.byte_ready, 0);
    push(8'hEF); push(8'hBE); push(8'hAD); push(8'hDE);
    chk("t2_w1_en", bus.wr_en, 1);
    chk("t2_w1_addr", bus.wr_addr, 1);
    chk("t2_w1_data", bus.wr_data, 32'hDEADBEEF);
    bus.byte_valid = 1'b0;
    tick();
    chk("t2_done", {load_done, core_rst_n, load_busy}, 3'b110);
    chk("t2_nwr", wlog.size(), 2);
    chk("t2_log0", wlog[0], {12'h000, 32'h12345678});
    chk("t2_log1", wlog[1], {12'h001, 32'hDEADBEEF});

    // Restart from DONE; gapped stream and a byte held through WRITE
    start(2);
    chk("t3_restart", {core_rst_n, load_done, load_busy}, 3'b001);
    wlog.delete();
    tick();
    push(8'h78);
    bus.byte_valid = 1'b0;
    tick(); tick();
    push(8'h56); push(8'h34);
    bus.byte_valid = 1'b0;
    tick();
    push(8'h12);
    bus.byte_data  = 8'hEF;
    bus.byte_valid = 1'b1;
    chk("t3_wr_ready", {bus.wr_en, bus.byte_ready}, 2'b10);
    tick();
    chk("t3_post_wr", {bus.wr_en, bus.byte_ready}, 2'b01);
    push(8'hEF);
    bus.byte_valid = 1'b0;
    tick();
    push(8'hBE); push(8'hAD);
    bus.byte_valid = 1'b0;
    tick(); tick();
    push(8'hDE);
    bus.byte_valid = 1'b0;
    tick();
    chk("t3_done", {load_done, core_rst_n}, 2'b11);
    chk("t3_nwr", wlog.size(), 2);
    chk("t3_log0", wlog[0], {12'h000, 32'h12345678});
    chk("t3_log1", wlog[1], {12'h001, 32'hDEADBEEF});

    // Timeout after a partial word, then a retry
    start(1);
    wlog.delete();
    push(8'h01); push(8'h02); push(8'h03);
    bus.byte_valid = 1'b0;
    repeat (TIMEOUT_CYCLES - 1) tick();
    chk("t4_pre_tmo", {load_err, load_busy}, 2'b01);
    tick();
    chk("t4_tmo", {load_err, load_busy, core_rst_n}, 3'b100);
    chk("t4_nwr", wlog.size(), 0);
    start(1);
    push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
    chk("t4_retry_addr", bus.wr_addr, 0);
    chk("t4_retry_data", bus.wr_data, 32'hDDCCBBAA);
    bus.byte_valid = 1'b0;
    tick();
    chk("t4_retry_done", {load_done, core_rst_n}, 2'b11);
    chk("t4_retry_nwr", wlog.size(), 1);

    // Length limits
    wlog.delete();
    start(13'd4097);
    chk("t5_toolong", {load_err, load_busy, load_done, core_rst_n}, 4'b1000);
    start(0);
    chk("t5_zero", {load_done, core_rst_n, load_busy, load_err}, 4'b1100);
    chk("t5_nwr", wlog.size(), 0);

    // Reset in the middle of the second word
    start(2);
    wlog.delete();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    push(8'h55); push(8'h66);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_status", {load_busy, load_done, load_err, core_rst_n}, 0);
    chk("t6_rst_bus", {bus.byte_ready, bus.wr_en, bus.wr_addr, bus.wr_data}, 0);
    bus.byte_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start(1);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    chk("t6_reload_addr", bus.wr_addr, 0);
    bus.byte_valid = 1'b0;
    tick();
    chk("t6_done", load_done, 1);
    chk("t6_nwr", wlog.size(), 2);
    chk("t6_log0", wlog[0], {12'h000, 32'h44332211});
    chk("t6_log1", wlog[1], {12'h000, 32'h04030201});

    // Full-depth load: last write lands at the top address, no wrap to 0
    start(13'd4096);
    wlog.delete();
    for (int w = 0; w < 4096; w++) begin
      wa = w[11:0];
      push(wa[7:0]); push({4'h0, wa[11:8]}); push(8'h5A); push(8'hC3);
    end
    bus.byte_valid = 1'b0;
    tick();
    chk("t7_done", {load_done, core_rst_n}, 2'b11);
    chk("t7_nwr", wlog.size(), 4096);
    chk("t7_first", wlog[0], {12'h000, 32'hC35A0000});
    chk("t7_last", wlog[4095], {12'hFFF, 32'hC35A0FFF});
    bad = 0;
    for (int w = 0; w < wlog.size(); w++) begin
      wa = w[11:0];
      if (wlog[w] !== {wa, 8'hC3, 8'h5A, 4'h0, wa[11:8], wa[7:0]}) bad++;
    end
    chk("t7_all_words", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the core's instruction fetch path.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word sequentially into the 4096-entry instruction RAM through a single write port.
- Holds the core in reset until a complete program has been written, so fetch starts from address 0 with valid contents.

Parameters:
- ADDR_W, 12, instruction RAM word-address width (depth 2^ADDR_W).
- TIMEOUT_CYCLES, 1024, consecutive RECV cycles with no accepted byte before the load aborts.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE and ERR.
- load_len  input  ADDR_W+1  number of words to load, sampled on the load_start cycle.
- byte_data  input  8  stream byte.
- byte_valid  input  1  byte_data is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction RAM write strobe.
- wr_addr  output  ADDR_W  word address.
- wr_data  output  32  word to write.
- load_busy  output  1  high in RECV and WRITE.
- load_done  output  1  high in DONE.
- load_err  output  1  high in ERR.
- core_rst_n  output  1  active-low core reset; 1 only in DONE.

Behaviour:
- Reset values: async reset forces state to IDLE and drives every output and counter to 0.
  - byte_ready=0, wr_en=0, wr_addr=0, wr_data=0.
  - load_busy=0, load_done=0, load_err=0, core_rst_n=0.
  - A partially assembled word is discarded and never written.
- All outputs are registered or decoded directly from state; there are no combinational input-to-output paths.
- IDLE/DONE/ERR → on load_start:
  - load_len==0 → DONE.
  - load_len>2^ADDR_W → ERR.
  - otherwise latch load_len, clear the word counter, byte index and timeout counter, and go to RECV.
- While loading, core_rst_n is 0 and load_done and load_err are both 0.
- RECV:
  - byte_ready=1.
  - A byte is accepted when byte_valid && byte_ready at a clock edge.
  - Byte index i (0..3) is placed at bits [8i+7:8i].
  - When the 4th byte is accepted, go to WRITE.
- WRITE (exactly one cycle):
  - byte_ready=0, wr_en=1, wr_addr=word count, wr_data=assembled word.
  - Increment the word counter.
  - If the new count equals load_len → DONE, else → RECV.
- Latency: wr_en is high in the cycle immediately after the edge that accepts the 4th byte of a word.
- Throughput: one word per 5 cycles at best (4 accept cycles plus 1 WRITE cycle).
- Timeout:
  - The counter increments in every RECV cycle with no accepted byte and clears on every accepted byte.
  - Reaching TIMEOUT_CYCLES → ERR; the partial word is dropped and no write is issued.
- load_start during RECV or WRITE is ignored, and load_len is not resampled.
- DONE: load_done=1, core_rst_n=1, held indefinitely.
  - A new load_start restarts loading, and core_rst_n drops to 0 on the next cycle.
- ERR: load_err=1, core_rst_n=0, held until load_start (retry) or reset.
- Writing the last word of a full load (load_len=2^ADDR_W) uses wr_addr=2^ADDR_W-1. The counter never wraps into a write at address 0.
- Asynchronous reset mid-operation: immediate return to IDLE, and the next load starts from address 0.

Test Plan:
- Reset → all outputs 0, including core_rst_n=0; byte_ready stays 0 with byte_valid=1 applied.
- load_len=2, continuous bytes 78 56 34 12 EF BE AD DE:
  - writes addr 0 = 0x12345678 and addr 1 = 0xDEADBEEF, each wr_en pulse exactly one cycle after the 4th byte;
  - then load_done=1, core_rst_n=1.
- Same stream with byte_valid gaps and a byte presented during a WRITE cycle → byte_ready=0 in WRITE, the byte is held and accepted next cycle; identical writes, no loss or duplication.
- Send 3 bytes then stop → after TIMEOUT_CYCLES idle cycles load_err=1, no wr_en, core_rst_n=0; a subsequent load_start with load_len=1 and 4 bytes succeeds at addr 0.
- load_len=0 → DONE one cycle after load_start with no writes; load_len=4097 → ERR with no writes.
- Assert rst_n=0 after 6 bytes of a 2-word load → outputs 0 immediately, addr 1 never written; a reload writes addr 0 again.
